// File: rtl/dice_fifo_pkg.sv
// Shared constants and helpers for the DICE RAM-backed stream FIFO.
package dice_fifo_pkg;

    localparam int OBUF_DEPTH = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 3);
    endfunction

    function automatic int unsigned wrap_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dice_fifo_obuf.sv
// Two-entry output skid buffer; head word drives the downstream stream.
module dice_fifo_obuf
    import dice_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] slot_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] slot_d [OBUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = slot_q[rd_ptr_q];

endmodule

// File: rtl/dice_ram_fifo_ctrl.sv
// Elastic FIFO controller around an external 1W/1R RAM with registered read.
// Define DICE_RAM_FIFO_BYPASS_EN to route pushes into an empty FIFO straight to the output buffer.
module dice_ram_fifo_ctrl
    import dice_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [2:0]           OBUF_C  = 3'(OBUF_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  push, pop, byp, wr_en, rd_en;
    logic                  obuf_push;
    logic [DATA_WIDTH-1:0] obuf_data;
    logic [1:0]            obuf_cnt;

    always_comb begin
        pop      = out_valid & out_ready;
        in_ready = rst_n & (ram_cnt_q != DEPTH_C);
        push     = in_valid & in_ready;
        // Space check includes the read already in flight and this cycle's pop.
        rd_en    = rst_n & (ram_cnt_q != '0)
                 & (({1'b0, obuf_cnt} + {2'b0, inflight_q})
                    < (OBUF_C + {2'b0, pop}));
`ifdef DICE_RAM_FIFO_BYPASS_EN
        byp      = (ram_cnt_q == '0) & ~inflight_q & ~rd_en
                 & ({1'b0, obuf_cnt} < (OBUF_C + {2'b0, pop}));
`else
        byp      = 1'b0;
`endif
        wr_en     = push & ~byp;
        obuf_push = inflight_q | (push & byp);
        obuf_data = inflight_q ? ram_rd_data : in_data;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = ADDR_WIDTH'(wrap_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_en) begin
            rd_ptr_d = ADDR_WIDTH'(wrap_inc(32'(rd_ptr_q), DEPTH));
        end
        ram_cnt_d  = ram_cnt_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
        inflight_d = rd_en;
        count_d    = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    dice_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (obuf_push),
        .push_data (obuf_data),
        .pop       (pop),
        .cnt       (obuf_cnt),
        .head      (out_data)
    );

    assign out_valid   = (obuf_cnt != 2'd0);
    assign ram_wr_en   = wr_en;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = in_data;
    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = rd_ptr_q;
    assign count       = count_q;

endmodule

// File: doc/dice_ram_fifo_ctrl.md
Name: dice_ram_fifo_ctrl

Overview:
- Stream FIFO controller that drives the write and read ports of an external 1-write/1-read RAM (1-cycle registered read latency, read gated by rd_en).
- Consumes the RAM's read data into a 2-entry output buffer and presents it downstream as a valid/ready stream.
- Sits directly upstream/downstream of the RAM macro and turns it into an elastic FIFO for DICE datapath buffering.

Parameters:
- DATA_WIDTH, 32, word width; equals the RAM's DATA_WIDTH.
- DEPTH, 1024, RAM entries; need not be a power of two; DEPTH >= 2.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- CNT_WIDTH, $clog2(DEPTH+3), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  DATA_WIDTH  upstream word.
- out_valid  output  1  downstream word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  head word.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  ADDR_WIDTH  RAM write address.
- ram_wr_data  output  DATA_WIDTH  RAM write data.
- ram_rd_en  output  1  RAM read enable.
- ram_rd_addr  output  ADDR_WIDTH  RAM read address.
- ram_rd_data  input  DATA_WIDTH  RAM read data; valid the cycle after ram_rd_en.
- count  output  CNT_WIDTH  total words held (RAM + in-flight + output buffer).

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, obuf_cnt=0, out_valid=0, count=0, out_data=0.
- While rst_n=0: in_ready=0, ram_wr_en=0, ram_rd_en=0.
- Reset asserted mid-operation discards all contents, including an in-flight read. The RAM array itself is not cleared.
- Push: push = in_valid & in_ready, with in_ready = (ram_cnt != DEPTH).
  - When pushing into the RAM: ram_wr_en=push, ram_wr_addr=wr_ptr, ram_wr_data=in_data (combinational).
  - wr_ptr increments and wraps DEPTH-1 -> 0.
- Read issue: ram_rd_en = (ram_cnt != 0) & (obuf_cnt + inflight - pop < 2), where pop = out_valid & out_ready.
  - ram_rd_addr = rd_ptr; rd_ptr wraps DEPTH-1 -> 0.
  - ram_cnt decrements on issue; inflight <= ram_rd_en (at most 1).
- Collision: ram_cnt counts only words already committed at a prior edge, so a read never targets the address being written in the same cycle. No read-during-write hazard exists.
- Capture: when inflight=1, ram_rd_data is written into the output buffer tail the same cycle.
- Output buffer: 2-entry FIFO, head drives out_data; out_valid = (obuf_cnt != 0).
  - Simultaneous pop and capture: the head advances and the capture lands in the correct slot.
  - Order is strictly preserved.
- Simultaneous events: push and read issue in the same cycle -> ram_cnt is unchanged.
- count = ram_cnt + inflight + obuf_cnt, registered; maximum DEPTH+2.
- Latency without bypass: word pushed in cycle 0 -> ram_rd_en cycle 1 -> captured cycle 2 -> out_valid cycle 3.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Full: in_ready=0 while ram_cnt==DEPTH. A pop plus read issue frees a slot visible the next cycle.
- Empty: ram_rd_en is never asserted while ram_cnt==0.

Optional Feature:
- Macro: DICE_RAM_FIFO_BYPASS_EN.
- Enabled:
  - Bypass condition: ram_cnt==0 & inflight==0 & ram_rd_en==0 & (obuf_cnt - pop < 2).
  - On a push under that condition, in_data is written directly into the output buffer and ram_wr_en stays 0.
  - Result: push in cycle 0 -> out_valid cycle 1. Order is preserved because the bypass applies only when nothing is older.
- Disabled: every word goes through the RAM; 3-cycle latency.

Decomposition:
- Shared package dice_fifo_pkg:
  - obuf depth constant OBUF_DEPTH=2;
  - function wrap_inc(ptr, DEPTH);
  - count-width helper.
- One sub-module: dice_fifo_obuf (2-entry output skid buffer with push/pop/cnt).
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Single word: push 0xA5A5_0001 at cycle 0, out_ready=1 -> out_valid at cycle 3 (cycle 1 with bypass), out_data=0xA5A5_0001, count returns to 0.
- Fill: DEPTH=4, out_ready=0, push 0..7 -> words 0,1 in obuf, 4 words in RAM; in_ready=0 after the 6th accepted word, count=6; drain yields 0..5 in order.
- Streaming: continuous push and pop of 100 incrementing words, out_ready=1 -> one word per cycle in steady state, no gaps, in order.
- Wrap: DEPTH=3 (non-power-of-two), push and pop 10 words interleaved -> ram_wr_addr/ram_rd_addr cycle 0,1,2,0,...; data intact.
- Backpressure: random out_ready (50%) with random in_valid over 1000 words -> scoreboard order matches, count == pushes - pops each cycle, ram_rd_en never asserted when ram_cnt==0.
- Reset mid-read: assert rst_n=0 the cycle after ram_rd_en -> out_valid=0, count=0; after release, a fresh push 0x1234 emerges alone, with no stale capture.
